// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master slice.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  // Wait counter width: enough to hold TIMEOUT_CYC, never less than one bit.
  function automatic int cnt_width(input int cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_mst_if.sv
// Local command/response port plus APB bus, bundled for the APB master.
interface apb_mst_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_timeout_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_timeout_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_timeout_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS cycles without pready and flags the abort cycle.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  input  logic pready_i,
  output logic expire
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_s;
      assign unused_s = &{1'b0, clk, rst_n, clear, run, pready_i};
      assign expire   = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
      logic [CNT_W-1:0] count_r;
      logic             stall_s;

      assign stall_s = run & ~pready_i;

      // Saturates at LAST; the FSM leaves ACCESS in that same cycle, so no wrap.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
          count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (count_r != LAST)) begin
          count_r <= count_r + CNT_W'(1);
        end else begin
          count_r <= count_r;
        end
      end

      assign expire = stall_s && (count_r == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_mst.sv
// APB master: one local command in, one APB transfer out, one response pulse back.
module apb_mst
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 15
) (
  input logic       pclk_i,
  input logic       prst_n,
  apb_mst_if.master bus
);

  apb_state_e        state_r;
  logic              psel_r;
  logic              penable_r;
  logic              pwrite_r;
  logic [ADDR_W-1:0] paddr_r;
  logic [DATA_W-1:0] pwdata_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_timeout_r;
  logic              cmd_ready_s;
  logic              accept_s;
  logic              expire_s;
  logic              wait_clear_s;
  logic              wait_run_s;

  // Ready in IDLE, or in a completing ACCESS cycle so the next SETUP follows directly.
  always_comb begin
    cmd_ready_s = 1'b0;
    case (state_r)
      IDLE:    cmd_ready_s = 1'b1;
      ACCESS:  cmd_ready_s = bus.pready_i;
      default: cmd_ready_s = 1'b0;
    endcase
  end

  assign accept_s     = bus.cmd_valid_i & cmd_ready_s;
  assign wait_clear_s = (state_r == SETUP);
  assign wait_run_s   = (state_r == ACCESS);

  apb_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk      (pclk_i),
    .rst_n    (prst_n),
    .clear    (wait_clear_s),
    .run      (wait_run_s),
    .pready_i (bus.pready_i),
    .expire   (expire_s)
  );

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge pclk_i) begin
    if (!prst_n) begin
      state_r       <= IDLE;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_W{1'b0}};
      pwdata_r      <= {DATA_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_timeout_r <= 1'b0;
    end else begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          penable_r <= 1'b0;
          if (accept_s) begin
            pwrite_r <= bus.cmd_write_i;
            paddr_r  <= bus.cmd_addr_i;
            pwdata_r <= bus.cmd_wdata_i;
            psel_r   <= 1'b1;
            state_r  <= SETUP;
          end else begin
            psel_r   <= 1'b0;
          end
        end
        SETUP: begin
          psel_r    <= 1'b1;
          penable_r <= 1'b1;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          // Completion takes priority over a timeout firing in the same cycle.
          if (bus.pready_i) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : bus.prdata_i;
            penable_r   <= 1'b0;
            if (accept_s) begin
              pwrite_r <= bus.cmd_write_i;
              paddr_r  <= bus.cmd_addr_i;
              pwdata_r <= bus.cmd_wdata_i;
              psel_r   <= 1'b1;
              state_r  <= SETUP;
            end else begin
              psel_r   <= 1'b0;
              state_r  <= IDLE;
            end
          end else if (expire_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_timeout_r <= 1'b1;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            state_r       <= IDLE;
          end else begin
            psel_r    <= 1'b1;
            penable_r <= 1'b1;
          end
        end
        default: begin
          psel_r    <= 1'b0;
          penable_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o   = cmd_ready_s;
  assign bus.psel_o        = psel_r;
  assign bus.penable_o     = penable_r;
  assign bus.pwrite_o      = pwrite_r;
  assign bus.paddr_o       = paddr_r;
  assign bus.pwdata_o      = pwdata_r;
  assign bus.rsp_valid_o   = rsp_valid_r;
  assign bus.rsp_rdata_o   = rsp_rdata_r;
  assign bus.rsp_timeout_o = rsp_timeout_r;

endmodule

// File: tb/tb_apb_mst.sv
// Self-checking bench for apb_mst: vector table, corner sequences, random commands.
module tb_apb_mst;
  import apb_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  apb_mst_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  apb_mst #(
    .ADDR_W      (8),
    .DATA_W      (32),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .pclk_i (clk),
    .prst_n (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    apb_cmd_t    cmd;
    int          waits;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Transaction-level rules: waits = number of pready=0 ACCESS cycles before pready=1.
  function automatic void ref_model(input apb_cmd_t c, input int waits, input logic [31:0] rd,
                                    output logic [31:0] rdata, output logic tmo, output int len);
    tmo   = (TMO > 0) && (waits >= TMO);
    len   = tmo ? TMO : waits + 1;
    rdata = (tmo || c.write) ? 32'h0 : rd;
  endfunction

  // Runs one command from IDLE; entered and left on a falling edge.
  task automatic xfer(input apb_cmd_t c, input int waits, input logic [31:0] rd,
                      input logic [31:0] exp_rd, input logic exp_tmo, input int exp_len);
    int acc;
    acc = 0;
    chk1("idle_ready", bus.cmd_ready_o, 1'b1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = c.write;
    bus.cmd_addr_i  = c.addr;
    bus.cmd_wdata_i = c.wdata;
    bus.pready_i    = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = ~c.write;
    bus.cmd_addr_i  = 8'($urandom);
    bus.cmd_wdata_i = $urandom;
    chk1("setup_psel", bus.psel_o, 1'b1);
    chk1("setup_penable", bus.penable_o, 1'b0);
    chk1("setup_pwrite", bus.pwrite_o, c.write);
    chk("setup_paddr", 32'(bus.paddr_o), 32'(c.addr));
    chk("setup_pwdata", bus.pwdata_o, c.wdata);
    chk1("setup_ready", bus.cmd_ready_o, 1'b0);
    for (int k = 0; k < TMO + 3; k++) begin
      @(negedge clk);
      if (!(bus.psel_o && bus.penable_o)) break;
      acc++;
      chk("acc_paddr", 32'(bus.paddr_o), 32'(c.addr));
      chk1("acc_pwrite", bus.pwrite_o, c.write);
      chk1("acc_rsp_quiet", bus.rsp_valid_o, 1'b0);
      bus.pready_i = (acc - 1 == waits);
      bus.prdata_i = bus.pready_i ? rd : $urandom;
      #1;
      chk1("acc_ready", bus.cmd_ready_o, (acc - 1 == waits));
    end
    bus.pready_i = 1'b0;
    bus.prdata_i = $urandom;
    chk("access_len", acc, exp_len);
    chk1("rsp_valid", bus.rsp_valid_o, 1'b1);
    chk("rsp_rdata", bus.rsp_rdata_o, exp_rd);
    chk1("rsp_timeout", bus.rsp_timeout_o, exp_tmo);
    chk1("end_psel", bus.psel_o, 1'b0);
    chk1("end_penable", bus.penable_o, 1'b0);
    @(negedge clk);
    chk1("pulse_end_valid", bus.rsp_valid_o, 1'b0);
    chk("pulse_end_rdata", bus.rsp_rdata_o, 32'h0);
    chk1("pulse_end_tmo", bus.rsp_timeout_o, 1'b0);
  endtask

  initial begin
    apb_cmd_t    c;
    logic [31:0] erd;
    logic        etmo;
    int          elen;
    int          w;
    logic [31:0] rd;

    vecs[0] = '{'{1'b1, 8'h10, 32'hDEADBEEF}, 0,  32'h12345678, 32'h00000000, 1'b0};
    vecs[1] = '{'{1'b0, 8'h10, 32'h00000000}, 3,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{'{1'b0, 8'h44, 32'h0000AAAA}, 30, 32'h55555555, 32'h00000000, 1'b1};
    vecs[3] = '{'{1'b0, 8'h20, 32'h00000000}, 0,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{'{1'b0, 8'h30, 32'h00000000}, 14, 32'h0BADF00D, 32'h0BADF00D, 1'b0};
    vecs[5] = '{'{1'b1, 8'h31, 32'h13579BDF}, 15, 32'h77777777, 32'h00000000, 1'b1};
    vecs[6] = '{'{1'b1, 8'hFF, 32'hFFFFFFFF}, 1,  32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[7] = '{'{1'b0, 8'h00, 32'h00000000}, 0,  32'h80000001, 32'h80000001, 1'b0};

    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = 8'h00;
    bus.cmd_wdata_i = 32'h0;
    bus.prdata_i    = 32'h0;
    bus.pready_i    = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_psel", bus.psel_o, 1'b0);
    chk1("rst_penable", bus.penable_o, 1'b0);
    chk1("rst_pwrite", bus.pwrite_o, 1'b0);
    chk("rst_paddr", 32'(bus.paddr_o), 32'h0);
    chk("rst_pwdata", bus.pwdata_o, 32'h0);
    chk1("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk1("rst_rsp_tmo", bus.rsp_timeout_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      ref_model(vecs[i].cmd, vecs[i].waits, vecs[i].prdata, erd, etmo, elen);
      xfer(vecs[i].cmd, vecs[i].waits, vecs[i].prdata, vecs[i].exp_rdata, vecs[i].exp_tmo, elen);
    end

    // Back-to-back: write 0x01 then read 0x02 with cmd_valid held.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b1;
    bus.cmd_addr_i  = 8'h01;
    bus.cmd_wdata_i = 32'hA1A2A3A4;
    @(negedge clk);
    chk1("b2b_setup1_psel", bus.psel_o, 1'b1);
    chk("b2b_setup1_paddr", 32'(bus.paddr_o), 32'h01);
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = 8'h02;
    #1;
    chk1("b2b_setup_ready", bus.cmd_ready_o, 1'b0);
    @(negedge clk);
    chk1("b2b_acc1_penable", bus.penable_o, 1'b1);
    bus.pready_i = 1'b1;
    bus.prdata_i = 32'h99999999;
    #1;
    chk1("b2b_acc1_ready", bus.cmd_ready_o, 1'b1);
    @(negedge clk);
    chk1("b2b_setup2_psel", bus.psel_o, 1'b1);
    chk1("b2b_setup2_penable", bus.penable_o, 1'b0);
    chk("b2b_setup2_paddr", 32'(bus.paddr_o), 32'h02);
    chk1("b2b_setup2_pwrite", bus.pwrite_o, 1'b0);
    chk1("b2b_rsp1_valid", bus.rsp_valid_o, 1'b1);
    chk("b2b_rsp1_rdata", bus.rsp_rdata_o, 32'h0);
    bus.cmd_valid_i = 1'b0;
    bus.pready_i    = 1'b0;
    @(negedge clk);
    chk1("b2b_acc2_penable", bus.penable_o, 1'b1);
    chk1("b2b_gap_valid", bus.rsp_valid_o, 1'b0);
    bus.pready_i = 1'b1;
    bus.prdata_i = 32'h0F0F1234;
    @(negedge clk);
    bus.pready_i = 1'b0;
    chk1("b2b_rsp2_valid", bus.rsp_valid_o, 1'b1);
    chk("b2b_rsp2_rdata", bus.rsp_rdata_o, 32'h0F0F1234);
    chk1("b2b_end_psel", bus.psel_o, 1'b0);
    @(negedge clk);
    chk1("b2b_after_valid", bus.rsp_valid_o, 1'b0);

    // Reset in the middle of a stalled write: everything drops, no response.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b1;
    bus.cmd_addr_i  = 8'h5A;
    bus.cmd_wdata_i = 32'h11223344;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk1("mid_penable", bus.penable_o, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk1("mrst_psel", bus.psel_o, 1'b0);
    chk1("mrst_penable", bus.penable_o, 1'b0);
    chk1("mrst_pwrite", bus.pwrite_o, 1'b0);
    chk("mrst_paddr", 32'(bus.paddr_o), 32'h0);
    chk("mrst_pwdata", bus.pwdata_o, 32'h0);
    chk1("mrst_rsp_valid", bus.rsp_valid_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("mrst_after_valid", bus.rsp_valid_o, 1'b0);
    chk1("mrst_after_psel", bus.psel_o, 1'b0);
    c = '{1'b0, 8'h66, 32'h0};
    ref_model(c, 2, 32'h600DCAFE, erd, etmo, elen);
    xfer(c, 2, 32'h600DCAFE, erd, etmo, elen);

    // Random commands against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      c.write = 1'($urandom);
      c.addr  = 8'($urandom);
      c.wdata = $urandom;
      w       = int'($urandom_range(0, 18));
      rd      = $urandom;
      ref_model(c, w, rd, erd, etmo, elen);
      xfer(c, w, rd, erd, etmo, elen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_mst.md
Name: apb_mst

Overview:
APB master that turns single-beat commands from a local request port into APB transfers (IDLE -> SETUP -> ACCESS) toward an APB_SLV-style completer.
- Returns one response pulse per command, carrying read data or a timeout flag.
- Aborts any transfer whose completer holds pready_i low for too long.
- Sits between a local controller (CPU or bus bridge) and the APB fabric.

Parameters:
ADDR_W, 8, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYC, 15, max consecutive ACCESS cycles with pready_i=0 before abort; 0 disables timeout

Ports:
pclk_i  in  1  clock; all logic on rising edge
prst_n  in  1  reset; synchronous, active-low
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_W  transfer address
cmd_wdata_i  in  DATA_W  write data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  DATA_W  read data, valid with rsp_valid_o
rsp_timeout_o  out  1  transfer aborted by timeout, valid with rsp_valid_o
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  ADDR_W  APB address
pwdata_o  out  DATA_W  APB write data
prdata_i  in  DATA_W  APB read data
pready_i  in  1  APB transfer done

Behaviour:
- Reset (prst_n=0 at a clock edge):
  - state=IDLE, wait count=0.
  - psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_rdata_o, rsp_timeout_o all 0.
  - Reset mid-transfer drops psel/penable next edge; no response is issued for the aborted command.
- All APB and rsp outputs are registered. cmd_ready_o is combinational from state and pready_i.
- cmd_ready_o=1 in IDLE, or in ACCESS when pready_i=1 (back-to-back); otherwise 0.
- States:
  - IDLE: psel=0, penable=0. On accept at cycle T: latch write/addr/wdata onto pwrite/paddr/pwdata; SETUP at T+1.
  - SETUP: psel=1, penable=0; unconditionally -> ACCESS next cycle.
  - ACCESS: psel=1, penable=1.
    - If pready_i=1: transfer completes. Next cycle rsp_valid_o=1, rsp_rdata_o=prdata_i for reads (0 for writes), rsp_timeout_o=0.
    - Then -> SETUP if a new command is accepted in the same cycle (psel stays 1, penable drops to 0), else -> IDLE.
- Latency with zero-wait completer: accept T, psel T+1, penable T+2, rsp_valid T+3. Back-to-back throughput is one transfer per 2 cycles.
- pwrite/paddr/pwdata stay stable from SETUP through the end of ACCESS. They hold their last value in IDLE.
- prdata_i is sampled only in ACCESS with pready_i=1.
- Wait counter:
  - Clears on entry to ACCESS.
  - Increments each ACCESS cycle with pready_i=0.
  - When pready_i=0 and count==TIMEOUT_CYC-1 (TIMEOUT_CYC>0): abort. Next cycle state=IDLE, psel=penable=0, rsp_valid_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - cmd_ready_o=0 in the abort cycle.
- pready_i=1 in the same cycle the timeout would fire: completion wins, no timeout.
- pready_i is ignored in IDLE and SETUP.
- No response backpressure. rsp_valid_o is a single-cycle pulse, 0 otherwise. rsp_rdata_o/rsp_timeout_o return to 0 when rsp_valid_o=0.
- Counter width = $clog2(TIMEOUT_CYC+1), minimum 1 bit; it must not wrap within one transfer.

Decomposition:
- Package apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS}
  - default ADDR_W/DATA_W localparams
  - command struct {write, addr, wdata}
- One sub-module, apb_wait_timer:
  - inputs: clear, pready_i, run
  - output: expire, when the counter hits TIMEOUT_CYC-1 with pready_i=0
  - tied off when TIMEOUT_CYC=0

Test Plan:
- Write addr 0x10 data 0xDEADBEEF, pready_i=1 at first ACCESS:
  - psel T+1, penable T+2, paddr=0x10, pwdata=0xDEADBEEF, pwrite=1 throughout.
  - rsp_valid T+3 with rdata=0, timeout=0.
- Read addr 0x10, completer inserts 3 wait states then drives prdata=0xDEADBEEF with pready=1:
  - penable high 4 cycles, addr stable.
  - rsp_rdata_o=0xDEADBEEF with rsp_valid_o, single pulse.
- Back-to-back: cmd_valid held with write 0x01 then read 0x02, zero-wait completer:
  - second SETUP directly follows first ACCESS (psel stays 1, penable 1->0).
  - Two rsp pulses 2 cycles apart.
- Timeout: pready_i held 0, TIMEOUT_CYC=15:
  - ACCESS lasts exactly 15 cycles, then psel/penable=0.
  - rsp_valid=1, rsp_timeout=1, rdata=0; a following command is accepted from IDLE.
- Race: pready_i=1 on the 15th ACCESS cycle → normal completion, rsp_timeout_o=0.
- Reset: prst_n=0 during ACCESS → next edge all outputs 0, state IDLE, no rsp_valid; a new read after release completes normally.
